// File: rtl/wb_port_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_scheduler_pkg
// Description : Shared types and constants for the write-back port scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_port_scheduler_pkg;

    localparam int unsigned ADDR_W           = 32;
    localparam int unsigned DATA_W           = 32;
    localparam int unsigned NUM_REGS         = 32;
    localparam int unsigned REG_IDX_W        = 5;
    localparam int unsigned STARVE_LIMIT_DEF = 4;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        STALL = 2'd2
    } sched_state_e;

    // One-hot register select; addresses outside the register file select nothing.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic             en,
                                                      input logic [ADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] v;
        v = '0;
        if (en && (addr != REG_ZERO) && (addr[ADDR_W-1:REG_IDX_W] == '0))
            v[addr[REG_IDX_W-1:0]] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_port_scheduler_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : wb_scoreboard
// Description : Tracks registers awaiting an MDU result (set on issue, clear on
//               accepted result, set wins on collision).
// Revision    : 1.0 - initial release
// ============================================================================
module wb_scoreboard
    import wb_port_scheduler_pkg::*;
(
    input  logic                clk,
    input  logic                i_rst_n,
    input  logic                i_set_en,
    input  logic [ADDR_W-1:0]   i_set_addr,
    input  logic                i_clr_en,
    input  logic [ADDR_W-1:0]   i_clr_addr,
    output logic [NUM_REGS-1:0] o_mask
);

    logic [NUM_REGS-1:0] r_mask;
    logic [NUM_REGS-1:0] w_set;
    logic [NUM_REGS-1:0] w_clr;

    assign w_set = reg_onehot(i_set_en, i_set_addr);
    assign w_clr = reg_onehot(i_clr_en, i_clr_addr);

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_mask <= '0;
        end else begin
            r_mask <= ((r_mask & ~w_clr) | w_set) & ~{{(NUM_REGS-1){1'b0}}, 1'b1};
        end
    end

    assign o_mask = r_mask;

endmodule
`default_nettype wire

// File: rtl/wb_port_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_scheduler
// Description : Arbitrates two pipe write-backs and a long-latency MDU result
//               onto two register-file write ports, with starvation stall.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_port_scheduler
    import wb_port_scheduler_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
)
(
    input  logic                clk,
    input  logic                btnc_i,
    input  logic                wb_we_i,
    input  logic [ADDR_W-1:0]   wb_addr_i,
    input  logic [DATA_W-1:0]   wb_data_i,
    input  logic                wb_we_r,
    input  logic [ADDR_W-1:0]   wb_addr_r,
    input  logic [DATA_W-1:0]   wb_data_r,
    input  logic                mdu_valid,
    input  logic [ADDR_W-1:0]   mdu_addr,
    input  logic [DATA_W-1:0]   mdu_data,
    output logic                mdu_ready,
    input  logic                mdu_issue,
    input  logic [ADDR_W-1:0]   mdu_issue_addr,
    output logic                port0_we,
    output logic [ADDR_W-1:0]   port0_addr,
    output logic [DATA_W-1:0]   port0_data,
    output logic                port1_we,
    output logic [ADDR_W-1:0]   port1_addr,
    output logic [DATA_W-1:0]   port1_data,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic                stall_req
);

    localparam int unsigned     CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] c_LIMIT = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] c_ONE   = CNT_W'(1);

    sched_state_e     r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_stall;

    logic             w_r_wr;
    logic             w_i_wr;
    logic             w_mdu_ready;
    logic             w_refused;
    logic             w_mdu_clash;
    logic             w_mdu_wr;
    logic             w_mdu_p1;
    logic [CNT_W-1:0] w_cnt_inc;

    // The r pipe is younger, so on a same-address collision its value is the one to keep.
    assign w_r_wr = btnc_i && wb_we_r && (wb_addr_r != REG_ZERO);
    assign w_i_wr = btnc_i && wb_we_i && (wb_addr_i != REG_ZERO)
                    && !(w_r_wr && (wb_addr_i == wb_addr_r));

    assign w_mdu_p1    = !w_r_wr;
    assign w_mdu_ready = btnc_i && mdu_valid && (!w_r_wr || !w_i_wr);
    assign w_refused   = mdu_valid && !w_mdu_ready;

    // A colliding MDU result is stale relative to the pipe write; drop it but still handshake.
    assign w_mdu_clash = (w_i_wr && (mdu_addr == wb_addr_i))
                      || (w_r_wr && (mdu_addr == wb_addr_r));
    assign w_mdu_wr    = w_mdu_ready && (mdu_addr != REG_ZERO) && !w_mdu_clash;

    always_comb begin
        port0_we   = w_i_wr;
        port0_addr = wb_addr_i;
        port0_data = wb_data_i;
        port1_we   = w_r_wr;
        port1_addr = wb_addr_r;
        port1_data = wb_data_r;
        if (w_mdu_wr) begin
            if (w_mdu_p1) begin
                port1_we   = 1'b1;
                port1_addr = mdu_addr;
                port1_data = mdu_data;
            end else begin
                port0_we   = 1'b1;
                port0_addr = mdu_addr;
                port0_data = mdu_data;
            end
        end
    end

    assign w_cnt_inc = (r_cnt >= c_LIMIT) ? c_LIMIT : r_cnt + c_ONE;

    // The refusal seen in IDLE is the first counted one; a limit of 1 goes straight to STALL.
    always_ff @(posedge clk) begin
        if (!btnc_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_stall <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_refused) begin
                        r_cnt <= c_ONE;
                        if (c_ONE >= c_LIMIT) begin
                            r_state <= STALL;
                            r_stall <= 1'b1;
                        end else begin
                            r_state <= WAIT;
                            r_stall <= 1'b0;
                        end
                    end else begin
                        r_cnt   <= '0;
                        r_stall <= 1'b0;
                    end
                end
                WAIT, STALL: begin
                    if (!mdu_valid || w_mdu_ready) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_stall <= 1'b0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc >= c_LIMIT) begin
                            r_state <= STALL;
                            r_stall <= 1'b1;
                        end else begin
                            r_state <= WAIT;
                            r_stall <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_stall <= 1'b0;
                end
            endcase
        end
    end

    assign mdu_ready = w_mdu_ready;
    assign stall_req = r_stall;

    wb_scoreboard u_scoreboard (
        .clk        (clk),
        .i_rst_n    (btnc_i),
        .i_set_en   (mdu_issue),
        .i_set_addr (mdu_issue_addr),
        .i_clr_en   (w_mdu_ready),
        .i_clr_addr (mdu_addr),
        .o_mask     (busy_mask)
    );

endmodule
`default_nettype wire

// File: tb/tb_wb_port_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_port_scheduler
// Description : Directed-vector scoreboard bench for wb_port_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_port_scheduler;

    logic        clk = 1'b0;
    logic        btnc_i;
    logic        wb_we_i, wb_we_r, mdu_valid, mdu_issue;
    logic [31:0] wb_addr_i, wb_data_i, wb_addr_r, wb_data_r;
    logic [31:0] mdu_addr, mdu_data, mdu_issue_addr;
    logic        mdu_ready, port0_we, port1_we, stall_req;
    logic [31:0] port0_addr, port0_data, port1_addr, port1_data, busy_mask;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       name;
        logic        we0;
        logic [31:0] a0, d0;
        logic        we1;
        logic [31:0] a1, d1;
        logic        rdy;
        logic [31:0] busy;
        logic        stall;
    } exp_t;

    exp_t q[$];

    wb_port_scheduler dut (
        .clk            (clk),
        .btnc_i         (btnc_i),
        .wb_we_i        (wb_we_i),
        .wb_addr_i      (wb_addr_i),
        .wb_data_i      (wb_data_i),
        .wb_we_r        (wb_we_r),
        .wb_addr_r      (wb_addr_r),
        .wb_data_r      (wb_data_r),
        .mdu_valid      (mdu_valid),
        .mdu_addr       (mdu_addr),
        .mdu_data       (mdu_data),
        .mdu_ready      (mdu_ready),
        .mdu_issue      (mdu_issue),
        .mdu_issue_addr (mdu_issue_addr),
        .port0_we       (port0_we),
        .port0_addr     (port0_addr),
        .port0_data     (port0_data),
        .port1_we       (port1_we),
        .port1_addr     (port1_addr),
        .port1_data     (port1_data),
        .busy_mask      (busy_mask),
        .stall_req      (stall_req)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input string n, input logic we0, input logic [31:0] a0, d0,
                                input logic we1, input logic [31:0] a1, d1,
                                input logic rdy, input logic [31:0] busy, input logic stall);
        exp_t e;
        e.name = n; e.we0 = we0; e.a0 = a0; e.d0 = d0;
        e.we1 = we1; e.a1 = a1; e.d1 = d1;
        e.rdy = rdy; e.busy = busy; e.stall = stall;
        return e;
    endfunction

    task automatic chk(input string n, input string f, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s.%s: got 0x%08h expected 0x%08h", n, f, act, exp);
        end
    endtask

    // Monitor: compares the expectation for the current cycle away from the clock edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.name, "port0_we",  {31'b0, port0_we},  {31'b0, e.we0});
            chk(e.name, "port1_we",  {31'b0, port1_we},  {31'b0, e.we1});
            chk(e.name, "mdu_ready", {31'b0, mdu_ready}, {31'b0, e.rdy});
            chk(e.name, "busy_mask", busy_mask,          e.busy);
            chk(e.name, "stall_req", {31'b0, stall_req}, {31'b0, e.stall});
            if (e.we0) begin
                chk(e.name, "port0_addr", port0_addr, e.a0);
                chk(e.name, "port0_data", port0_data, e.d0);
            end
            if (e.we1) begin
                chk(e.name, "port1_addr", port1_addr, e.a1);
                chk(e.name, "port1_data", port1_data, e.d1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic rn,
                       input logic wi, input logic [31:0] ai, di,
                       input logic wr, input logic [31:0] ar, dr,
                       input logic mv, input logic [31:0] ma, md,
                       input logic iss, input logic [31:0] ia);
        btnc_i = rn;
        wb_we_i = wi; wb_addr_i = ai; wb_data_i = di;
        wb_we_r = wr; wb_addr_r = ar; wb_data_r = dr;
        mdu_valid = mv; mdu_addr = ma; mdu_data = md;
        mdu_issue = iss; mdu_issue_addr = ia;
    endtask

    initial begin
        drv(0, 0,0,0, 0,0,0, 0,0,0, 0,0);
        tick();
        // Reset holds ports and ready low even with live requests
        drv(0, 1,3,32'h33, 0,0,0, 1,7,32'hAB, 1,7);
        q.push_back(mk("reset", 0,0,0, 0,0,0, 0, 32'h0, 0));
        tick();
        drv(1, 0,0,0, 0,0,0, 0,0,0, 1,7);
        q.push_back(mk("issue7", 0,0,0, 0,0,0, 0, 32'h0, 0));
        tick();
        drv(1, 1,5,32'h11, 1,5,32'h22, 0,0,0, 0,0);
        q.push_back(mk("same_addr", 0,0,0, 1,5,32'h22, 0, 32'h80, 0));
        tick();
        drv(1, 1,3,32'h33, 0,0,0, 1,7,32'hAB, 0,0);
        q.push_back(mk("mdu_p1", 1,3,32'h33, 1,7,32'hAB, 1, 32'h80, 0));
        tick();
        drv(1, 0,0,0, 0,0,0, 0,0,0, 1,9);
        q.push_back(mk("clr7", 0,0,0, 0,0,0, 0, 32'h0, 0));
        tick();
        drv(1, 0,0,0, 0,0,0, 1,9,32'h99, 1,9);
        q.push_back(mk("set_clr9", 0,0,0, 1,9,32'h99, 1, 32'h200, 0));
        tick();
        drv(1, 0,0,0, 1,4,32'h44, 1,9,32'h55, 0,0);
        q.push_back(mk("mdu_p0", 1,9,32'h55, 1,4,32'h44, 1, 32'h200, 0));
        tick();
        drv(1, 1,8,32'h88, 0,0,0, 1,8,32'h77, 0,0);
        q.push_back(mk("mdu_clash", 1,8,32'h88, 0,0,0, 1, 32'h0, 0));
        tick();
        drv(1, 1,32'h80000005,32'h1, 1,5,32'h2, 0,0,0, 0,0);
        q.push_back(mk("addr32", 1,32'h80000005,32'h1, 1,5,32'h2, 0, 32'h0, 0));
        tick();
        drv(1, 1,0,32'h12, 1,0,32'h34, 1,0,32'hEE, 1,0);
        q.push_back(mk("zero_addr", 0,0,0, 0,0,0, 1, 32'h0, 0));
        tick();
        drv(1, 0,0,0, 0,0,0, 0,0,0, 1,7);
        q.push_back(mk("zero_after", 0,0,0, 0,0,0, 0, 32'h0, 0));
        for (int k = 0; k < 4; k++) begin
            tick();
            drv(1, 1,1,32'h01, 1,2,32'h02, 1,7,32'hC7, 0,0);
            q.push_back(mk($sformatf("refuse%0d", k), 1,1,32'h01, 1,2,32'h02, 0, 32'h80, 0));
        end
        tick();
        q.push_back(mk("stall_on", 1,1,32'h01, 1,2,32'h02, 0, 32'h80, 1));
        tick();
        drv(1, 1,1,32'h01, 0,0,0, 1,7,32'hC7, 0,0);
        q.push_back(mk("stall_hs", 1,1,32'h01, 1,7,32'hC7, 1, 32'h80, 1));
        tick();
        drv(1, 0,0,0, 0,0,0, 0,0,0, 1,7);
        q.push_back(mk("stall_off", 0,0,0, 0,0,0, 0, 32'h0, 0));
        for (int k = 0; k < 4; k++) begin
            tick();
            drv(1, 1,1,32'h01, 1,2,32'h02, 1,7,32'hC7, 0,0);
            q.push_back(mk($sformatf("refuseB%0d", k), 1,1,32'h01, 1,2,32'h02, 0, 32'h80, 0));
        end
        tick();
        drv(0, 1,1,32'h01, 1,2,32'h02, 1,7,32'hC7, 0,0);
        q.push_back(mk("rst_in_stall", 0,0,0, 0,0,0, 0, 32'h80, 1));
        tick();
        drv(1, 0,0,0, 0,0,0, 0,0,0, 0,0);
        q.push_back(mk("post_rst", 0,0,0, 0,0,0, 0, 32'h0, 0));
        for (int k = 0; k < 5 && q.size() > 0; k++) tick();
        if (q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
